// File: rtl/player_attack_fx.sv
// player_attack_fx
// Attack-effect renderer for the 2x-scaled tile grid. A rising edge on one of
// the attack buttons starts a timed attack: "normal" lights a line of RADIUS
// tiles in the facing direction, "special" lights a diamond of tiles around
// the player. After the attack comes a cooldown in which all presses are ignored.
// For every VGA pixel inside the lit pattern, the block fetches a sprite-ROM
// texel. All other pixels get the transparent key colour.
//
// Ports
//   clk                    system clock, rising edge
//   rst                    asynchronous reset, active low
//   attack_normal_pressed  level, normal-attack button
//   attack_special_pressed level, special-attack button
//   h_cnt, v_cnt           VGA column / row (unscaled)
//   player_x, player_y     player tile position
//   player_dir             0 up, 1 right, 2 down, 3 left
//   rom_addr               sprite-ROM address {mode, texel offset}; 0 when no hit
//   rom_data               ROM read data for the registered rom_addr
//   pixel_attack           texel colour, or KEY_RGB
//   attack_active          high while an attack is being shown
//   attack_mode            0 normal, 1 special (meaningful while active)
//   attack_done            one-cycle pulse when an attack ends
//
// Latency from h_cnt/v_cnt to pixel_attack is two clocks.
module player_attack_fx #(
    parameter int          GRID_W   = 20,
    parameter int          GRID_H   = 10,
    parameter int          TILE     = 16,
    parameter int          RADIUS   = 2,
    parameter int          DUR_NORM = 12500000,
    parameter int          DUR_SPEC = 33554432,
    parameter int          COOLDOWN = 6250000,
    parameter logic [11:0] KEY_RGB  = 12'hCBE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        attack_normal_pressed,
    input  logic        attack_special_pressed,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic [1:0]  player_dir,
    output logic [16:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] pixel_attack,
    output logic        attack_active,
    output logic        attack_mode,
    output logic        attack_done
);

    localparam int TB      = $clog2(TILE);
    localparam int MAX_ACT = (DUR_NORM > DUR_SPEC) ? DUR_NORM : DUR_SPEC;
    localparam int MAX_ALL = (MAX_ACT > COOLDOWN) ? MAX_ACT : COOLDOWN;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] LD_NORM = CW'(DUR_NORM - 1);
    localparam logic [CW-1:0] LD_SPEC = CW'(DUR_SPEC - 1);
    localparam logic [CW-1:0] LD_COOL = CW'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        SPEC = 2'd2,
        COOL = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          mode_q, mode_nxt;
    logic          done_q, done_nxt;
    logic          latch_en;
    logic          norm_prev, spec_prev;
    logic          norm_edge, spec_edge;
    logic [9:0]    px_q, py_q;
    logic [1:0]    dir_q;
    logic          active;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign norm_edge = attack_normal_pressed & ~norm_prev;
    assign spec_edge = attack_special_pressed & ~spec_prev;
    assign active    = (state == NORM) || (state == SPEC);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            dir_q     <= '0;
            // The previous-level registers come out of reset as "held".
            // This way a button held through reset needs a fresh press.
            norm_prev <= 1'b1;
            spec_prev <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mode_q    <= mode_nxt;
            done_q    <= done_nxt;
            // Edge history is tracked in every state. An edge during an
            // attack or cooldown is therefore consumed and not remembered.
            norm_prev <= attack_normal_pressed;
            spec_prev <= attack_special_pressed;
            if (latch_en) begin
                // Kept already reduced into the grid, so the hit test needs
                // no second wrap of the player position.
                px_q  <= 10'(int'(player_x) % GRID_W);
                py_q  <= 10'(int'(player_y) % GRID_H);
                dir_q <= player_dir;
            end
        end
    end

    // NOTE: every signal driven here gets a default before the case. Without
    // one, a path that skips an assignment would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        done_nxt  = 1'b0;
        latch_en  = 1'b0;
        case (state)
            IDLE: begin
                if (spec_edge) begin
                    state_nxt = SPEC;
                    cnt_nxt   = LD_SPEC;
                    mode_nxt  = 1'b1;
                    latch_en  = 1'b1;
                end else if (norm_edge) begin
                    state_nxt = NORM;
                    cnt_nxt   = LD_NORM;
                    mode_nxt  = 1'b0;
                    latch_en  = 1'b1;
                end
            end
            NORM, SPEC: begin
                if (cnt == '0) begin
                    state_nxt = COOL;
                    cnt_nxt   = LD_COOL;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            COOL: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign attack_active = active;
    assign attack_mode   = mode_q;
    assign attack_done   = done_q;

    // ------------------------------------------------------------------
    // Hit test against the latched pattern
    // ------------------------------------------------------------------
    logic [8:0]      hc, vc;
    logic [8:0]      sx, sy;
    logic            on_grid;
    logic [2*TB-1:0] offset;
    int              rel_x, rel_y, abs_x, abs_y;
    logic            hit_norm, hit_spec, pix_hit;

    assign hc      = h_cnt[9:1];
    assign vc      = v_cnt[9:1];
    assign sx      = hc >> TB;
    assign sy      = vc >> TB;
    assign on_grid = (int'(hc) < GRID_W * TILE) && (int'(vc) < GRID_H * TILE);
    assign offset  = {vc[TB-1:0], hc[TB-1:0]};

    always_comb begin
        // Tile position relative to the player, folded into 0..GRID-1.
        // "GRID-1" therefore means one tile left/up, across the grid edge.
        rel_x = (GRID_W + int'(sx) - int'(px_q)) % GRID_W;
        rel_y = (GRID_H + int'(sy) - int'(py_q)) % GRID_H;
        abs_x = (rel_x > GRID_W / 2) ? GRID_W - rel_x : rel_x;
        abs_y = (rel_y > GRID_H / 2) ? GRID_H - rel_y : rel_y;

        hit_norm = 1'b0;
        case (dir_q)
            2'd0:    hit_norm = (rel_x == 0) && (rel_y >= GRID_H - RADIUS);
            2'd1:    hit_norm = (rel_y == 0) && (rel_x >= 1) && (rel_x <= RADIUS);
            2'd2:    hit_norm = (rel_x == 0) && (rel_y >= 1) && (rel_y <= RADIUS);
            default: hit_norm = (rel_y == 0) && (rel_x >= GRID_W - RADIUS);
        endcase

        hit_spec = (abs_x + abs_y <= RADIUS) && (abs_x + abs_y != 0);
    end

    assign pix_hit = on_grid && (((state == NORM) && hit_norm) ||
                                 ((state == SPEC) && hit_spec));

    // ------------------------------------------------------------------
    // Two-stage pixel pipeline
    // ------------------------------------------------------------------
    logic hit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr     <= '0;
            hit_q        <= 1'b0;
            pixel_attack <= KEY_RGB;
        end else begin
            rom_addr     <= pix_hit ? {mode_q, 16'(offset)} : '0;
            hit_q        <= pix_hit;
            // Rechecking the state blanks the texel that is still in flight
            // when an attack ends.
            pixel_attack <= (hit_q && active) ? rom_data : KEY_RGB;
        end
    end

    // The LSBs of the VGA counters are dropped by the 2x scaling.
    logic unused_lsb;
    assign unused_lsb = h_cnt[0] ^ v_cnt[0];

endmodule

// File: tb/tb_player_attack_fx.sv
`timescale 1ns/1ps
module tb_player_attack_fx;

    localparam int          GRID_W   = 20;
    localparam int          GRID_H   = 10;
    localparam int          TILE     = 16;
    localparam int          RADIUS   = 2;
    localparam int          DUR_NORM = 8;
    localparam int          DUR_SPEC = 16;
    localparam int          COOLDOWN = 4;
    localparam logic [11:0] KEY      = 12'hCBE;

    logic        clk = 1'b0;
    logic        rst;
    logic        attack_normal_pressed, attack_special_pressed;
    logic [9:0]  h_cnt, v_cnt, player_x, player_y;
    logic [1:0]  player_dir;
    logic [16:0] rom_addr;
    logic [11:0] rom_data, pixel_attack;
    logic        attack_active, attack_mode, attack_done;

    always #5 clk = ~clk;

    // ROM stand-in: the texel colour is the low address bits.
    assign rom_data = rom_addr[11:0];

    player_attack_fx #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .TILE(TILE), .RADIUS(RADIUS),
        .DUR_NORM(DUR_NORM), .DUR_SPEC(DUR_SPEC), .COOLDOWN(COOLDOWN),
        .KEY_RGB(KEY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .attack_normal_pressed(attack_normal_pressed),
        .attack_special_pressed(attack_special_pressed),
        .h_cnt(h_cnt),
        .v_cnt(v_cnt),
        .player_x(player_x),
        .player_y(player_y),
        .player_dir(player_dir),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .pixel_attack(pixel_attack),
        .attack_active(attack_active),
        .attack_mode(attack_mode),
        .attack_done(attack_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: attack time left, cooldown left, and the lit
    // tile set enumerated from the pattern rules.
    // ------------------------------------------------------------------
    int          m_left, m_cool, m_px, m_py, m_dir;
    bit          m_mode, m_prev_n, m_prev_s, m_done, m_hit1;
    logic [16:0] m_addr1;
    logic [11:0] m_pix;
    bit          cmp_model = 1'b0;

    task automatic model_reset();
        m_left = 0; m_cool = 0; m_px = 0; m_py = 0; m_dir = 0;
        m_mode = 1'b0; m_prev_n = 1'b1; m_prev_s = 1'b1; m_done = 1'b0;
        m_hit1 = 1'b0; m_addr1 = '0; m_pix = KEY;
    endtask

    function automatic bit in_pattern(int sx, int sy);
        int ddx, ddy;
        ddx = (m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0;
        ddy = (m_dir == 2) ? 1 : (m_dir == 0) ? -1 : 0;
        if (!m_mode) begin
            for (int k = 1; k <= RADIUS; k++)
                if ((m_px + k * ddx + GRID_W) % GRID_W == sx &&
                    (m_py + k * ddy + GRID_H) % GRID_H == sy) return 1'b1;
        end else begin
            for (int dx = -RADIUS; dx <= RADIUS; dx++)
                for (int dy = -RADIUS; dy <= RADIUS; dy++)
                    if ((dx != 0 || dy != 0) &&
                        ((dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy) <= RADIUS) &&
                        (m_px + dx + GRID_W) % GRID_W == sx &&
                        (m_py + dy + GRID_H) % GRID_H == sy) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        int hc, vc;
        bit hit_now, rise_n, rise_s;
        hc = int'(h_cnt) >> 1;
        vc = int'(v_cnt) >> 1;
        m_pix   = (m_hit1 && m_left > 0) ? m_addr1[11:0] : KEY;
        hit_now = (m_left > 0) && hc < GRID_W * TILE && vc < GRID_H * TILE &&
                  in_pattern(hc / TILE, vc / TILE);
        m_addr1 = hit_now ? {m_mode, 16'(hc % TILE + TILE * (vc % TILE))} : 17'h0;
        m_hit1  = hit_now;
        rise_n  = attack_normal_pressed && !m_prev_n;
        rise_s  = attack_special_pressed && !m_prev_s;
        m_done  = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_cool = COOLDOWN;
                m_done = 1'b1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (rise_s || rise_n) begin
            m_mode = rise_s;
            m_left = rise_s ? DUR_SPEC : DUR_NORM;
            m_px   = int'(player_x) % GRID_W;
            m_py   = int'(player_y) % GRID_H;
            m_dir  = int'(player_dir);
        end
        m_prev_n = attack_normal_pressed;
        m_prev_s = attack_special_pressed;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        if (cmp_model) begin
            check("rnd_pixel", pixel_attack, m_pix);
            check("rnd_addr", rom_addr, m_addr1);
            check("rnd_active", attack_active, m_left > 0);
            check("rnd_done", attack_done, m_done);
            if (m_left > 0) check("rnd_mode", attack_mode, m_mode);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: one attack per entry, one probed tile each.
    // The probe pixel sits at texel (5,9), so its texel offset is 0x095.
    // ------------------------------------------------------------------
    typedef struct {
        bit mode;
        int px, py, dir;
        int sx, sy;
        bit hit;
    } vec_t;

    function automatic vec_t mkv(bit mode, int px, int py, int dir, int sx, int sy, bit hit);
        vec_t v;
        v.mode = mode; v.px = px; v.py = py; v.dir = dir;
        v.sx = sx; v.sy = sy; v.hit = hit;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int tx, ty;

        vecs.push_back(mkv(1, 5, 5, 0, 5, 3, 1));
        vecs.push_back(mkv(1, 5, 5, 0, 5, 5, 0));
        vecs.push_back(mkv(1, 5, 5, 0, 6, 4, 1));
        vecs.push_back(mkv(1, 5, 5, 0, 7, 5, 1));
        vecs.push_back(mkv(1, 5, 5, 0, 8, 5, 0));
        vecs.push_back(mkv(1, 5, 5, 0, 7, 6, 0));
        vecs.push_back(mkv(0, 5, 5, 1, 6, 5, 1));
        vecs.push_back(mkv(0, 5, 5, 1, 7, 5, 1));
        vecs.push_back(mkv(0, 5, 5, 1, 4, 5, 0));
        vecs.push_back(mkv(0, 5, 5, 1, 8, 5, 0));
        vecs.push_back(mkv(0, 5, 5, 0, 5, 3, 1));
        vecs.push_back(mkv(0, 5, 5, 0, 5, 6, 0));
        vecs.push_back(mkv(0, 5, 5, 2, 5, 7, 1));
        vecs.push_back(mkv(0, 5, 5, 3, 3, 5, 1));
        vecs.push_back(mkv(0, 5, 5, 3, 6, 5, 0));
        vecs.push_back(mkv(1, 0, 0, 0, 19, 0, 1));
        vecs.push_back(mkv(1, 0, 0, 0, 18, 0, 1));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 9, 1));
        vecs.push_back(mkv(1, 0, 0, 0, 0, 8, 1));
        vecs.push_back(mkv(1, 0, 0, 0, 19, 9, 1));
        vecs.push_back(mkv(1, 0, 0, 0, 17, 0, 0));
        vecs.push_back(mkv(0, 0, 4, 3, 18, 4, 1));
        vecs.push_back(mkv(0, 19, 9, 2, 19, 1, 1));

        // ---------------- reset state ----------------
        rst = 1'b0;
        attack_normal_pressed = 1'b0; attack_special_pressed = 1'b0;
        h_cnt = '0; v_cnt = '0; player_x = 10'd5; player_y = 10'd5; player_dir = 2'd1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", rom_addr, 17'h0);
        check("rst_pixel", pixel_attack, KEY);
        check("rst_active", attack_active, 1'b0);
        check("rst_mode", attack_mode, 1'b0);
        check("rst_done", attack_done, 1'b0);
        rst = 1'b1;
        model_reset();
        tick(); tick();

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            player_x   = 10'(vecs[i].px);
            player_y   = 10'(vecs[i].py);
            player_dir = 2'(vecs[i].dir);
            h_cnt = 10'(2 * (vecs[i].sx * TILE + 5));
            v_cnt = 10'(2 * (vecs[i].sy * TILE + 9));
            if (vecs[i].mode) attack_special_pressed = 1'b1;
            else              attack_normal_pressed  = 1'b1;
            tick();
            attack_normal_pressed = 1'b0; attack_special_pressed = 1'b0;
            check($sformatf("vec%0d_active", i), attack_active, 1'b1);
            check($sformatf("vec%0d_mode", i), attack_mode, vecs[i].mode);
            tick();
            check($sformatf("vec%0d_addr", i), rom_addr,
                  vecs[i].hit ? {vecs[i].mode, 16'h0095} : 17'h0);
            tick();
            check($sformatf("vec%0d_pixel", i), pixel_attack, vecs[i].hit ? 12'h095 : KEY);
            repeat (DUR_SPEC + COOLDOWN) tick();
        end

        // ---------------- priority, done timing, lockout ----------------
        player_x = 10'd5; player_y = 10'd5; player_dir = 2'd0;
        h_cnt = '0; v_cnt = '0;
        attack_normal_pressed = 1'b1; attack_special_pressed = 1'b1;
        tick();
        check("prio_active", attack_active, 1'b1);
        check("prio_mode", attack_mode, 1'b1);
        for (int k = 1; k <= 22; k++) begin
            attack_normal_pressed  = (k <= 18) && (k % 2 == 0);
            attack_special_pressed = (k <= 18) && (k % 2 == 0);
            tick();
            check($sformatf("lock_active_%0d", k), attack_active, k < DUR_SPEC);
            check($sformatf("lock_done_%0d", k), attack_done, k == DUR_SPEC);
        end
        attack_normal_pressed = 1'b1;
        tick();
        attack_normal_pressed = 1'b0;
        check("retrig_active", attack_active, 1'b1);
        check("retrig_mode", attack_mode, 1'b0);
        repeat (DUR_NORM + COOLDOWN + 2) tick();

        // ---------------- latency and off-grid ----------------
        player_x = 10'd5; player_y = 10'd5; player_dir = 2'd1;
        h_cnt = 10'(2 * (5 * TILE + 5));
        v_cnt = 10'(2 * (5 * TILE + 9));
        attack_normal_pressed = 1'b1;
        tick();
        attack_normal_pressed = 1'b0;
        tick(); tick();
        check("lat_own_tile", pixel_attack, KEY);
        h_cnt = 10'(2 * (6 * TILE + 5));
        tick();
        check("lat_cycle1_pixel", pixel_attack, KEY);
        check("lat_cycle1_addr", rom_addr, 17'h00095);
        tick();
        check("lat_cycle2_pixel", pixel_attack, 12'h095);
        h_cnt = 10'd640;
        tick();
        check("offgrid_addr", rom_addr, 17'h0);
        check("offgrid_cycle1_pixel", pixel_attack, 12'h095);
        tick();
        check("offgrid_pixel", pixel_attack, KEY);
        repeat (DUR_NORM + COOLDOWN) tick();

        // ---------------- reset mid-attack ----------------
        player_x = 10'd5; player_y = 10'd5;
        h_cnt = 10'(2 * (5 * TILE + 5));
        v_cnt = 10'(2 * (3 * TILE + 9));
        attack_special_pressed = 1'b1;
        tick();
        repeat (4) tick();
        check("pre_rst_pixel", pixel_attack, 12'h095);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_active", attack_active, 1'b0);
        check("mid_rst_pixel", pixel_attack, KEY);
        check("mid_rst_done", attack_done, 1'b0);
        check("mid_rst_addr", rom_addr, 17'h0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        for (int k = 1; k <= 24; k++) begin
            tick();
            check($sformatf("post_rst_active_%0d", k), attack_active, 1'b0);
            check($sformatf("post_rst_done_%0d", k), attack_done, 1'b0);
        end
        attack_special_pressed = 1'b0;
        tick();

        // ---------------- randomized run against the model ----------------
        cmp_model = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0)  attack_normal_pressed  = ~attack_normal_pressed;
            if ($urandom_range(0, 11) == 0) attack_special_pressed = ~attack_special_pressed;
            if ($urandom_range(0, 31) == 0) begin
                player_x   = 10'($urandom_range(0, GRID_W - 1));
                player_y   = 10'($urandom_range(0, GRID_H - 1));
                player_dir = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                h_cnt = 10'($urandom_range(0, 799));
                v_cnt = 10'($urandom_range(0, 524));
            end else begin
                tx = (int'(player_x) + GRID_W + int'($urandom_range(0, 6)) - 3) % GRID_W;
                ty = (int'(player_y) + GRID_H + int'($urandom_range(0, 6)) - 3) % GRID_H;
                h_cnt = 10'(2 * (tx * TILE + int'($urandom_range(0, TILE - 1))) +
                            int'($urandom_range(0, 1)));
                v_cnt = 10'(2 * (ty * TILE + int'($urandom_range(0, TILE - 1))) +
                            int'($urandom_range(0, 1)));
            end
            tick();
        end
        cmp_model = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
